// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and queue entry type for the instruction prefetcher (FETCH_RRESP_CHECK_EN adds a fault bit)
package fetch_pkg;

  localparam int FETCH_INSTR_W = 32;

  // Fixed AR attributes: single 32-bit INCR-less beat, normal non-cacheable bufferable
  localparam logic [1:0] FETCH_ARBURST = 2'b00;
  localparam logic [3:0] FETCH_ARCACHE = 4'b0011;
  localparam logic [2:0] FETCH_ARSIZE  = 3'b010;
  localparam logic [2:0] FETCH_ARPROT  = 3'b000;

  typedef struct packed {
    logic [31:0]              pc;
    logic [FETCH_INSTR_W-1:0] command;
`ifdef FETCH_RRESP_CHECK_EN
    logic                     fault;
`endif
  } fetch_entry_t;

endpackage

// File: rtl/fetch_prefetch_if.sv
// rtl/fetch_prefetch_if.sv - AXI read-address/read-data port plus fetched-word stream (FETCH_RRESP_CHECK_EN adds out_fault)
interface fetch_prefetch_if #(
  parameter int ADDR_W = 15,
  parameter int ID_W   = 4
);

  logic [ADDR_W-1:0]                  araddr;
  logic [1:0]                         arburst;
  logic [3:0]                         arcache;
  logic [ID_W-1:0]                    arid;
  logic [7:0]                         arlen;
  logic                               arlock;
  logic [2:0]                         arprot;
  logic [3:0]                         arqos;
  logic [2:0]                         arsize;
  logic                               arvalid;
  logic                               arready;
  logic [fetch_pkg::FETCH_INSTR_W-1:0] rdata;
  logic [ID_W-1:0]                    rid;
  logic                               rlast;
  logic [1:0]                         rresp;
  logic                               rvalid;
  logic                               rready;
  logic                               out_valid;
  logic                               out_ready;
  logic [31:0]                        out_pc;
  logic [fetch_pkg::FETCH_INSTR_W-1:0] out_command;
`ifdef FETCH_RRESP_CHECK_EN
  logic                               out_fault;
`endif

  modport master (
`ifdef FETCH_RRESP_CHECK_EN
    output out_fault,
`endif
    output araddr, arburst, arcache, arid, arlen, arlock, arprot, arqos, arsize, arvalid,
    output rready, out_valid, out_pc, out_command,
    input  arready, rdata, rid, rlast, rresp, rvalid, out_ready
  );

  modport slave (
`ifdef FETCH_RRESP_CHECK_EN
    input  out_fault,
`endif
    input  araddr, arburst, arcache, arid, arlen, arlock, arprot, arqos, arsize, arvalid,
    input  rready, out_valid, out_pc, out_command,
    output arready, rdata, rid, rlast, rresp, rvalid, out_ready
  );

endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - synchronous FIFO of fetched words with clear and occupancy count
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clear,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  fetch_entry_t      mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;

  // Storage and pointers; clear drops everything including a same-cycle pop/push
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_prefetch.sv
// rtl/fetch_prefetch.sv - sequential instruction prefetcher with redirect flush (optional FETCH_RRESP_CHECK_EN fault tagging)
module fetch_prefetch
  import fetch_pkg::*;
#(
  parameter int          ADDR_W   = 15,
  parameter int          DEPTH    = 4,
  parameter int          ID_W     = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  fetch_prefetch_if.master  bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = CW + 1;

  logic [31:0]       fetch_pc;
  logic [31:0]       resp_pc;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     drop;
  logic [CW-1:0]     count;
  logic              arvalid_q;
  logic [ADDR_W-1:0] araddr_q;
  logic              rready_q;
  logic              stall;
  logic              ar_hs;
  logic              r_hs;
  logic              push;
  logic              pop;
  logic              issue_seq;
  logic              issue_redir;
  logic [SW-1:0]     inflight;
  logic [SW-1:0]     redir_inflight;
  fetch_entry_t      push_data;
  fetch_entry_t      head;
  logic              unused_r;

  assign ar_hs = arvalid_q && bus.arready;
  assign r_hs  = bus.rvalid && rready_q;
  assign push  = r_hs && (drop == '0) && !redirect;
  assign pop   = bus.out_valid && bus.out_ready;

  // Credit: every word either in flight or buffered owns a queue slot
  assign inflight       = SW'(outstanding) + SW'(count);
  assign redir_inflight = SW'(outstanding) - SW'(r_hs);
  assign issue_seq      = !arvalid_q && !redirect && !stall && (inflight < SW'(DEPTH));
  assign issue_redir    = !arvalid_q && redirect && (redir_inflight < SW'(DEPTH));

  // Request issue, in-flight/drop bookkeeping and PC tracking
  always_ff @(posedge clk) begin
    if (!rstn) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
      arvalid_q   <= 1'b0;
      araddr_q    <= '0;
      rready_q    <= 1'b0;
    end else begin
      rready_q    <= 1'b1;
      outstanding <= outstanding + CW'(ar_hs) - CW'(r_hs);
      if (redirect) drop <= outstanding - CW'(r_hs) + CW'(arvalid_q);
      else if (r_hs && (drop != '0)) drop <= drop - CW'(1);
      if (redirect) resp_pc <= redirect_pc;
      else if (push) resp_pc <= resp_pc + 32'd4;
      if (ar_hs) begin
        arvalid_q <= 1'b0;
      end else if (issue_redir) begin
        arvalid_q <= 1'b1;
        araddr_q  <= redirect_pc[ADDR_W-1:0];
      end else if (issue_seq) begin
        arvalid_q <= 1'b1;
        araddr_q  <= fetch_pc[ADDR_W-1:0];
      end
      // fetch_pc advances at issue so a stale pending AR cannot disturb it
      if (issue_redir) fetch_pc <= redirect_pc + 32'd4;
      else if (redirect) fetch_pc <= redirect_pc;
      else if (issue_seq) fetch_pc <= fetch_pc + 32'd4;
    end
  end

`ifdef FETCH_RRESP_CHECK_EN
  // Once a faulting word is buffered, stop fetching until the core redirects
  always_ff @(posedge clk) begin
    if (!rstn) stall <= 1'b0;
    else if (redirect) stall <= 1'b0;
    else if (push && bus.rresp[1]) stall <= 1'b1;
  end
  assign push_data.fault = bus.rresp[1];
  assign bus.out_fault   = head.fault;
`else
  assign stall = 1'b0;
`endif

  assign push_data.pc      = resp_pc;
  assign push_data.command = bus.rdata;

  fetch_queue #(.DEPTH(DEPTH), .CW(CW)) u_queue (
    .clk       (clk),
    .rstn      (rstn),
    .clear     (redirect),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  assign bus.out_valid   = (count != '0);
  assign bus.out_pc      = head.pc;
  assign bus.out_command = head.command;

  assign bus.araddr  = araddr_q;
  assign bus.arvalid = arvalid_q;
  assign bus.rready  = rready_q;
  assign bus.arburst = FETCH_ARBURST;
  assign bus.arcache = FETCH_ARCACHE;
  assign bus.arid    = '0;
  assign bus.arlen   = 8'd0;
  assign bus.arlock  = 1'b0;
  assign bus.arprot  = FETCH_ARPROT;
  assign bus.arqos   = 4'd0;
  assign bus.arsize  = FETCH_ARSIZE;

  assign unused_r = ^{bus.rid, bus.rlast, bus.rresp};

endmodule
